// File: rtl/c7bbiu_wr_ctl_pkg.sv
// Shared AXI constants, FSM encoding and capture payload for the BIU write controller.
package c7bbiu_wr_ctl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;

    localparam logic [ID_W-1:0] AXI_WID_LSU   = 4'h3;
    localparam logic [2:0]      AXI_SIZE_WORD = 3'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/c7bbiu_wr_ctl_if.sv
// AXI write-channel bundle (AW, W, B) between the BIU write controller and the fabric.
interface c7bbiu_wr_ctl_if;
    import c7bbiu_wr_ctl_pkg::*;

    logic              axi_aw_valid;
    logic              axi_aw_ready;
    logic [ID_W-1:0]   axi_aw_id;
    logic [ADDR_W-1:0] axi_aw_addr;
    logic [7:0]        axi_aw_len;
    logic [2:0]        axi_aw_size;
    logic [1:0]        axi_aw_burst;
    logic              axi_aw_lock;
    logic [3:0]        axi_aw_cache;
    logic [2:0]        axi_aw_prot;

    logic              axi_w_valid;
    logic              axi_w_ready;
    logic [ID_W-1:0]   axi_w_id;
    logic [DATA_W-1:0] axi_w_data;
    logic [STRB_W-1:0] axi_w_strb;
    logic              axi_w_last;

    logic              axi_b_valid;
    logic [ID_W-1:0]   axi_b_id;
    logic [1:0]        axi_b_resp;
    logic              axi_b_ready;

    modport master (
        output axi_aw_valid, axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size,
               axi_aw_burst, axi_aw_lock, axi_aw_cache, axi_aw_prot,
        input  axi_aw_ready,
        output axi_w_valid, axi_w_id, axi_w_data, axi_w_strb, axi_w_last,
        input  axi_w_ready,
        input  axi_b_valid, axi_b_id, axi_b_resp,
        output axi_b_ready
    );

    modport slave (
        input  axi_aw_valid, axi_aw_id, axi_aw_addr, axi_aw_len, axi_aw_size,
               axi_aw_burst, axi_aw_lock, axi_aw_cache, axi_aw_prot,
        output axi_aw_ready,
        input  axi_w_valid, axi_w_id, axi_w_data, axi_w_strb, axi_w_last,
        output axi_w_ready,
        output axi_b_valid, axi_b_id, axi_b_resp,
        input  axi_b_ready
    );

endinterface

// File: rtl/c7bbiu_wr_timer.sv
// B-response watchdog: saturating counter that flags the cycle the count reaches TIMEOUT_CYC-1.
module c7bbiu_wr_timer #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero timeout disables the watchdog entirely.
    assign expired_c_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/c7bbiu_wr_ctl.sv
// LSU store sequencer: one outstanding single-beat AXI write, AW and W driven independently,
// B response checked by id, with a watchdog forcing an error completion.
module c7bbiu_wr_ctl
    import c7bbiu_wr_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lsu_biu_wr_req,
    input  logic [ADDR_W-1:0] lsu_biu_wr_addr,
    input  logic [DATA_W-1:0] lsu_biu_wr_data,
    input  logic [STRB_W-1:0] lsu_biu_wr_strb,
    output logic              biu_lsu_wr_ack,
    output logic              biu_lsu_wr_done,
    output logic              biu_lsu_wr_err,
    output logic              wr_busy,
    c7bbiu_wr_ctl_if.master   axi
);

    wr_state_e state_q, state_d;
    wr_req_t   cap_q, cap_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;
    logic      done_q, done_d;
    logic      err_q, err_d;

    logic      ack_c;
    logic      aw_valid_c;
    logic      w_valid_c;
    logic      b_ready_c;
    logic      b_match_c;
    logic      b_err_c;
    logic      expired_c;

    c7bbiu_wr_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .clr_i       (state_q != ST_WAIT_B),
        .en_i        (state_q == ST_WAIT_B),
        .expired_c_o (expired_c)
    );

    assign b_match_c = axi.axi_b_valid && (axi.axi_b_id == AXI_WID_LSU);
    assign b_err_c   = (axi.axi_b_resp == AXI_RESP_SLVERR) || (axi.axi_b_resp == AXI_RESP_DECERR);

    // Next-state and channel control.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ack_c      = 1'b0;
        aw_valid_c = 1'b0;
        w_valid_c  = 1'b0;
        b_ready_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The done cycle refuses a new request so the LSU sees done before the next ack.
                ack_c = lsu_biu_wr_req && !done_q;
                if (ack_c) begin
                    cap_d     = '{addr: lsu_biu_wr_addr, data: lsu_biu_wr_data,
                                  strb: lsu_biu_wr_strb};
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                aw_valid_c = !aw_done_q;
                w_valid_c  = !w_done_q;
                if (aw_valid_c && axi.axi_aw_ready) aw_done_d = 1'b1;
                if (w_valid_c && axi.axi_w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                b_ready_c = 1'b1;
                if (b_match_c) begin
                    done_d  = 1'b1;
                    err_d   = b_err_c;
                    state_d = ST_IDLE;
                end else if (expired_c) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cap_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign biu_lsu_wr_ack  = ack_c;
    assign biu_lsu_wr_done = done_q;
    assign biu_lsu_wr_err  = err_q;
    assign wr_busy         = (state_q != ST_IDLE);

    assign axi.axi_aw_valid = aw_valid_c;
    assign axi.axi_aw_id    = AXI_WID_LSU;
    assign axi.axi_aw_addr  = cap_q.addr;
    assign axi.axi_aw_len   = 8'd0;
    assign axi.axi_aw_size  = AXI_SIZE_WORD;
    assign axi.axi_aw_burst = 2'd0;
    assign axi.axi_aw_lock  = 1'b0;
    assign axi.axi_aw_cache = 4'd0;
    assign axi.axi_aw_prot  = 3'd0;

    assign axi.axi_w_valid  = w_valid_c;
    assign axi.axi_w_id     = AXI_WID_LSU;
    assign axi.axi_w_data   = cap_q.data;
    assign axi.axi_w_strb   = cap_q.strb;
    assign axi.axi_w_last   = 1'b1;

    assign axi.axi_b_ready  = b_ready_c;

endmodule

// File: tb/tb_c7bbiu_wr_ctl.sv
// Directed bench for c7bbiu_wr_ctl with a short watchdog (TIMEOUT_CYC = 8).
module tb_c7bbiu_wr_ctl;
    import c7bbiu_wr_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        ack;
    logic        done;
    logic        err;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    c7bbiu_wr_ctl_if axi ();

    c7bbiu_wr_ctl #(.TIMEOUT_CYC(8)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .lsu_biu_wr_req  (req),
        .lsu_biu_wr_addr (addr),
        .lsu_biu_wr_data (data),
        .lsu_biu_wr_strb (strb),
        .biu_lsu_wr_ack  (ack),
        .biu_lsu_wr_done (done),
        .biu_lsu_wr_err  (err),
        .wr_busy         (busy),
        .axi             (axi)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here, checks follow a #2 settle.
    task automatic cy();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; addr = '0; data = '0; strb = '0;
        axi.axi_aw_ready = 1'b0; axi.axi_w_ready = 1'b0;
        axi.axi_b_valid = 1'b0; axi.axi_b_id = '0; axi.axi_b_resp = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #12;
        total++; if ({ack, done, err, busy} !== 4'b0) begin bad++;
            $display("FAIL reset_outs got=%b want=0000", {ack, done, err, busy}); end
        total++; if ({axi.axi_aw_valid, axi.axi_w_valid, axi.axi_b_ready} !== 3'b0) begin bad++;
            $display("FAIL reset_axi got=%b want=000", {axi.axi_aw_valid, axi.axi_w_valid, axi.axi_b_ready}); end
        total++; if (axi.axi_aw_addr !== 32'h0 || axi.axi_w_data !== 32'h0) begin bad++;
            $display("FAIL reset_cap got=%h/%h want=0/0", axi.axi_aw_addr, axi.axi_w_data); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        cy(); req = 1'b1; addr = 32'h1000_0040; data = 32'hDEAD_BEEF; strb = 4'hF;
        axi.axi_aw_ready = 1'b1; axi.axi_w_ready = 1'b1; #2;
        total++; if (ack !== 1'b1 || busy !== 1'b0 || axi.axi_aw_valid !== 1'b0) begin bad++;
            $display("FAIL basic_ack got=%b%b%b want=100", ack, busy, axi.axi_aw_valid); end
        cy(); req = 1'b0; #2;
        total++; if (axi.axi_aw_valid !== 1'b1 || axi.axi_w_valid !== 1'b1 || ack !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL basic_send got=%b%b%b%b want=1101", axi.axi_aw_valid, axi.axi_w_valid, ack, busy); end
        total++; if (axi.axi_aw_addr !== 32'h1000_0040 || axi.axi_w_data !== 32'hDEAD_BEEF || axi.axi_w_strb !== 4'hF) begin bad++;
            $display("FAIL basic_payload got=%h/%h/%h want=10000040/deadbeef/f", axi.axi_aw_addr, axi.axi_w_data, axi.axi_w_strb); end
        total++; if ({axi.axi_aw_id, axi.axi_aw_len, axi.axi_aw_size, axi.axi_aw_burst, axi.axi_aw_lock,
                      axi.axi_aw_cache, axi.axi_aw_prot, axi.axi_w_id, axi.axi_w_last}
                     !== {4'h3, 8'd0, 3'd2, 2'd0, 1'b0, 4'd0, 3'd0, 4'h3, 1'b1}) begin bad++;
            $display("FAIL basic_consts got=%h/%h/%h/%b", axi.axi_aw_id, axi.axi_aw_len, axi.axi_aw_size, axi.axi_w_last); end
        cy(); #2;
        total++; if (axi.axi_b_ready !== 1'b1 || axi.axi_aw_valid !== 1'b0 || axi.axi_w_valid !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL basic_waitb got=%b%b%b%b want=1000", axi.axi_b_ready, axi.axi_aw_valid, axi.axi_w_valid, done); end
        cy(); axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b00; #2;
        cy(); axi.axi_b_valid = 1'b0; #2;
        total++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || ack !== 1'b0) begin bad++;
            $display("FAIL basic_done got=%b%b%b%b want=1000", done, err, busy, ack); end
        cy(); #2;
        total++; if (done !== 1'b0) begin bad++;
            $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_aw_stall();
        cy(); req = 1'b1; addr = 32'h2000_0008; data = 32'h1234_5678; strb = 4'h3;
        axi.axi_aw_ready = 1'b0; axi.axi_w_ready = 1'b1; #2;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL stall_ack got=%b want=1", ack); end
        cy(); req = 1'b0; #2;
        total++; if (axi.axi_aw_valid !== 1'b1 || axi.axi_w_valid !== 1'b1) begin bad++;
            $display("FAIL stall_t1 got=%b%b want=11", axi.axi_aw_valid, axi.axi_w_valid); end
        for (int i = 0; i < 2; i++) begin
            cy(); #2;
            total++; if (axi.axi_aw_valid !== 1'b1 || axi.axi_w_valid !== 1'b0 || axi.axi_aw_addr !== 32'h2000_0008) begin bad++;
                $display("FAIL stall_hold%0d got=%b%b/%h want=10/20000008", i, axi.axi_aw_valid, axi.axi_w_valid, axi.axi_aw_addr); end
        end
        cy(); axi.axi_aw_ready = 1'b1;
        axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b00; #2;
        total++; if (axi.axi_aw_valid !== 1'b1 || axi.axi_b_ready !== 1'b0) begin bad++;
            $display("FAIL stall_aw_hs got=%b%b want=10", axi.axi_aw_valid, axi.axi_b_ready); end
        cy(); #2;
        total++; if (axi.axi_aw_valid !== 1'b0 || axi.axi_b_ready !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL stall_b got=%b%b%b want=010", axi.axi_aw_valid, axi.axi_b_ready, done); end
        cy(); axi.axi_b_valid = 1'b0; #2;
        total++; if (done !== 1'b1 || err !== 1'b0) begin bad++;
            $display("FAIL stall_done got=%b%b want=10", done, err); end
    endtask

    task automatic test_bad_id();
        cy(); req = 1'b1; addr = 32'h3000_0000; data = 32'hCAFE_F00D; strb = 4'hC;
        axi.axi_aw_ready = 1'b1; axi.axi_w_ready = 1'b1; #2;
        cy(); req = 1'b0; #2;
        cy(); axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h5; axi.axi_b_resp = 2'b00; #2;
        total++; if (axi.axi_b_ready !== 1'b1) begin bad++; $display("FAIL badid_ready got=%b want=1", axi.axi_b_ready); end
        cy(); axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b10; #2;
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL badid_drop got=%b%b want=01", done, busy); end
        cy(); axi.axi_b_valid = 1'b0; #2;
        total++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL badid_slverr got=%b%b%b want=110", done, err, busy); end
    endtask

    task automatic test_timeout();
        cy(); req = 1'b1; addr = 32'h4000_0010; data = 32'h0BAD_0BAD; strb = 4'hF;
        axi.axi_aw_ready = 1'b1; axi.axi_w_ready = 1'b1; #2;
        cy(); req = 1'b0; #2;
        for (int i = 0; i < 8; i++) begin
            cy(); #2;
            total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++;
                $display("FAIL timeout_wait%0d got=%b%b want=01", i, done, busy); end
        end
        cy(); req = 1'b1; addr = 32'h4000_0020; data = 32'h5555_AAAA; #2;
        total++; if (done !== 1'b1 || err !== 1'b1 || ack !== 1'b0) begin bad++;
            $display("FAIL timeout_done got=%b%b%b want=110", done, err, ack); end
        cy(); #2;
        total++; if (ack !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL timeout_reack got=%b%b want=10", ack, done); end
        cy(); req = 1'b0; #2;
        total++; if (axi.axi_aw_addr !== 32'h4000_0020) begin bad++;
            $display("FAIL timeout_addr got=%h want=40000020", axi.axi_aw_addr); end
        cy(); axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b01; #2;
        cy(); axi.axi_b_valid = 1'b0; #2;
        total++; if (done !== 1'b1 || err !== 1'b0) begin bad++;
            $display("FAIL timeout_next_done got=%b%b want=10", done, err); end
    endtask

    task automatic test_reset_mid();
        cy(); req = 1'b1; addr = 32'h5000_0000; data = 32'h7777_7777; strb = 4'h1;
        axi.axi_aw_ready = 1'b0; axi.axi_w_ready = 1'b0; #2;
        cy(); req = 1'b0; #2;
        total++; if (axi.axi_aw_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", axi.axi_aw_valid); end
        resetn = 1'b0; #1;
        total++; if ({axi.axi_aw_valid, axi.axi_w_valid, busy, done} !== 4'b0) begin bad++;
            $display("FAIL rstmid_async got=%b want=0000", {axi.axi_aw_valid, axi.axi_w_valid, busy, done}); end
        #2; resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cy(); #2;
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++;
                $display("FAIL rstmid_nodone%0d got=%b%b want=00", i, done, busy); end
        end
        cy(); req = 1'b1; addr = 32'h5000_0100; data = 32'h8888_0001; strb = 4'hF;
        axi.axi_aw_ready = 1'b1; axi.axi_w_ready = 1'b1; #2;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rstmid_ack got=%b want=1", ack); end
        cy(); req = 1'b0; #2;
        cy(); axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b00; #2;
        cy(); axi.axi_b_valid = 1'b0; #2;
        total++; if (done !== 1'b1 || err !== 1'b0) begin bad++;
            $display("FAIL rstmid_fresh got=%b%b want=10", done, err); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        cy(); req = 1'b1; addr = 32'h6000_0000; data = 32'hA5A5_A5A5; strb = 4'hF;
        axi.axi_aw_ready = 1'b1; axi.axi_w_ready = 1'b1;
        axi.axi_b_valid = 1'b1; axi.axi_b_id = 4'h3; axi.axi_b_resp = 2'b00;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) cy();
            #2;
            total++; if (ack !== ((i % 4) == 0)) begin bad++;
                $display("FAIL b2b_ack%0d got=%b want=%b", i, ack, (i % 4) == 0); end
            total++; if (ack && busy) begin bad++;
                $display("FAIL b2b_busy%0d got=ack1 busy1 want=not both", i); end
            if (done) n_done++;
        end
        cy(); req = 1'b0; axi.axi_b_valid = 1'b0; #2;
        total++; if (n_done !== 4) begin bad++; $display("FAIL b2b_dones got=%0d want=4", n_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_bad_id();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

endmodule
